control_unit: RTL and testbench

Finite-state control unit for the 8-bit computer's CPU. It sequences instruction fetch, decode and execute by driving every select and load strobe of the CPU data path. It consumes the instruction register value and the registered NZVC flags that the data path returns. Together with the data path it forms the CPU; `write` goes directly to the memory system.

---
 rtl/control_unit.sv | 176 +++++++++++++++++
 tb/tb_control_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: Moore FSM that sequences fetch, decode and execute for the
// 8-bit CPU by driving every data path select and load strobe. Outputs decode
// from the state register only and are held at zero while reset is asserted.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic       CCR_Load,
  output logic [2:0] ALU_Sel,
  output logic [1:0] Bus1_Sel,
  output logic [1:0] Bus2_Sel,
  output logic       write
);

  // Each opcode-specific execute step gets its own state so that the outputs
  // stay a pure function of the state register; IR only steers transitions.
  typedef enum logic [4:0] {
    S_F0, S_F1, S_F2, S_D3,
    S_OP4, S_OP5,
    S_LDA_IMM, S_LDB_IMM,
    S_DIR_ADDR, S_LD_WAIT, S_LDA_DIR, S_LDB_DIR,
    S_STA, S_STB,
    S_ADD, S_SUB, S_AND, S_OR, S_INCA, S_DECA, S_INCB, S_DECB,
    S_BR_ADDR, S_BR_WAIT, S_BR_LOAD, S_BR_SKIP
  } state_t;

  localparam logic [1:0] BUS1_PC  = 2'b00;
  localparam logic [1:0] BUS1_A   = 2'b01;
  localparam logic [1:0] BUS1_B   = 2'b10;
  localparam logic [1:0] BUS2_ALU = 2'b00;
  localparam logic [1:0] BUS2_B1  = 2'b01;
  localparam logic [1:0] BUS2_MEM = 2'b10;

  state_t state, next_state;
  logic   br_taken;
  logic   br_op;

  // State register; reset parks the FSM at the start of fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_F0;
    else        state <= next_state;
  end

  // Next-state selection and Moore output decode.
  always_comb begin
    next_state = S_F0;
    IR_Load    = 1'b0;
    MAR_Load   = 1'b0;
    PC_Load    = 1'b0;
    PC_Inc     = 1'b0;
    A_Load     = 1'b0;
    B_Load     = 1'b0;
    CCR_Load   = 1'b0;
    ALU_Sel    = 3'b000;
    Bus1_Sel   = BUS1_PC;
    Bus2_Sel   = BUS2_ALU;
    write      = 1'b0;
    br_op      = 1'b1;
    br_taken   = 1'b0;

    // Branch condition from the registered flags {N,Z,V,C}.
    case (IR)
      8'h20:   br_taken = 1'b1;
      8'h21:   br_taken = CCR_Result[3];
      8'h22:   br_taken = ~CCR_Result[3];
      8'h23:   br_taken = CCR_Result[2];
      8'h24:   br_taken = ~CCR_Result[2];
      8'h25:   br_taken = CCR_Result[1];
      8'h26:   br_taken = ~CCR_Result[1];
      8'h27:   br_taken = CCR_Result[0];
      8'h28:   br_taken = ~CCR_Result[0];
      default: br_op    = 1'b0;
    endcase

    case (state)
      S_F0: begin
        Bus1_Sel = BUS1_PC; Bus2_Sel = BUS2_B1; MAR_Load = 1'b1;
        next_state = S_F1;
      end
      S_F1: begin
        PC_Inc = 1'b1;
        next_state = S_F2;
      end
      S_F2: begin
        Bus2_Sel = BUS2_MEM; IR_Load = 1'b1;
        next_state = S_D3;
      end
      S_D3: begin
        if (br_op) begin
          next_state = br_taken ? S_BR_ADDR : S_BR_SKIP;
        end else begin
          case (IR)
            8'h86, 8'h87, 8'h88, 8'h89,
            8'h96, 8'h97: next_state = S_OP4;
            8'h42:        next_state = S_ADD;
            8'h43:        next_state = S_SUB;
            8'h44:        next_state = S_AND;
            8'h45:        next_state = S_OR;
            8'h46:        next_state = S_INCA;
            8'h47:        next_state = S_INCB;
            8'h48:        next_state = S_DECA;
            8'h49:        next_state = S_DECB;
            default:      next_state = S_F0;
          endcase
        end
      end
      S_OP4: begin
        Bus1_Sel = BUS1_PC; Bus2_Sel = BUS2_B1; MAR_Load = 1'b1;
        next_state = S_OP5;
      end
      S_OP5: begin
        PC_Inc = 1'b1;
        case (IR)
          8'h86:   next_state = S_LDA_IMM;
          8'h88:   next_state = S_LDB_IMM;
          default: next_state = S_DIR_ADDR;
        endcase
      end
      S_LDA_IMM: begin Bus2_Sel = BUS2_MEM; A_Load = 1'b1; end
      S_LDB_IMM: begin Bus2_Sel = BUS2_MEM; B_Load = 1'b1; end
      S_DIR_ADDR: begin
        // Operand byte is an address: load it into MAR for the second read.
        Bus2_Sel = BUS2_MEM; MAR_Load = 1'b1;
        case (IR)
          8'h96:   next_state = S_STA;
          8'h97:   next_state = S_STB;
          default: next_state = S_LD_WAIT;
        endcase
      end
      S_LD_WAIT: next_state = (IR == 8'h87) ? S_LDA_DIR : S_LDB_DIR;
      S_LDA_DIR: begin Bus2_Sel = BUS2_MEM; A_Load = 1'b1; end
      S_LDB_DIR: begin Bus2_Sel = BUS2_MEM; B_Load = 1'b1; end
      S_STA: begin Bus1_Sel = BUS1_A; write = 1'b1; end
      S_STB: begin Bus1_Sel = BUS1_B; write = 1'b1; end
      S_ADD:  begin ALU_Sel = 3'b000; Bus1_Sel = BUS1_A; A_Load = 1'b1; CCR_Load = 1'b1; end
      S_SUB:  begin ALU_Sel = 3'b001; Bus1_Sel = BUS1_A; A_Load = 1'b1; CCR_Load = 1'b1; end
      S_AND:  begin ALU_Sel = 3'b010; Bus1_Sel = BUS1_A; A_Load = 1'b1; CCR_Load = 1'b1; end
      S_OR:   begin ALU_Sel = 3'b011; Bus1_Sel = BUS1_A; A_Load = 1'b1; CCR_Load = 1'b1; end
      S_INCA: begin ALU_Sel = 3'b100; Bus1_Sel = BUS1_A; A_Load = 1'b1; CCR_Load = 1'b1; end
      S_DECA: begin ALU_Sel = 3'b101; Bus1_Sel = BUS1_A; A_Load = 1'b1; CCR_Load = 1'b1; end
      S_INCB: begin ALU_Sel = 3'b100; Bus1_Sel = BUS1_B; B_Load = 1'b1; CCR_Load = 1'b1; end
      S_DECB: begin ALU_Sel = 3'b101; Bus1_Sel = BUS1_B; B_Load = 1'b1; CCR_Load = 1'b1; end
      S_BR_ADDR: begin
        Bus1_Sel = BUS1_PC; Bus2_Sel = BUS2_B1; MAR_Load = 1'b1;
        next_state = S_BR_WAIT;
      end
      S_BR_WAIT: next_state = S_BR_LOAD;
      S_BR_LOAD: begin Bus2_Sel = BUS2_MEM; PC_Load = 1'b1; end
      S_BR_SKIP: PC_Inc = 1'b1;
      default:   next_state = S_F0;
    endcase

    // Reset overrides the state decode so nothing strobes while held.
    if (!reset) begin
      IR_Load  = 1'b0;
      MAR_Load = 1'b0;
      PC_Load  = 1'b0;
      PC_Inc   = 1'b0;
      A_Load   = 1'b0;
      B_Load   = 1'b0;
      CCR_Load = 1'b0;
      ALU_Sel  = 3'b000;
      Bus1_Sel = 2'b00;
      Bus2_Sel = 2'b00;
      write    = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: builds the expected per-cycle output sequence of each
// instruction from its cycle-by-cycle behaviour and compares it every cycle.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic       write;

  control_unit dut (
    .clk(clk), .reset(reset), .IR(IR), .CCR_Result(CCR_Result),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .A_Load(A_Load), .B_Load(B_Load), .CCR_Load(CCR_Load), .ALU_Sel(ALU_Sel),
    .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .write(write)
  );

  always #5 clk = ~clk;

  // Packed view: IRL MARL PCL PCI AL BL CCL ALU[3] BUS1[2] BUS2[2] WR
  logic [14:0] act;
  assign act = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
                ALU_Sel, Bus1_Sel, Bus2_Sel, write};

  localparam logic [14:0] IRL  = 15'h4000;
  localparam logic [14:0] MARL = 15'h2000;
  localparam logic [14:0] PCL  = 15'h1000;
  localparam logic [14:0] PCI  = 15'h0800;
  localparam logic [14:0] AL   = 15'h0400;
  localparam logic [14:0] BL   = 15'h0200;
  localparam logic [14:0] CCL  = 15'h0100;
  localparam logic [14:0] WR   = 15'h0001;

  function automatic logic [14:0] alu(input int c); return 15'(c) << 5; endfunction
  function automatic logic [14:0] b1(input int c);  return 15'(c) << 3; endfunction
  function automatic logic [14:0] b2(input int c);  return 15'(c) << 1; endfunction

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];

  task automatic chk(input string name, input logic [14:0] got, input logic [14:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s ir=%02h ccr=%b got=%b want=%b", name, IR, CCR_Result, got, want);
    end
  endtask

  // Expected output word for every cycle of one instruction, F0 onward.
  task automatic model(input logic [7:0] op, input logic [3:0] ccr);
    int k;
    bit taken;
    logic [14:0] reg_ld;
    exp_q.push_back(MARL | b1(0) | b2(1));   // F0: MAR <- PC
    exp_q.push_back(PCI);                    // F1
    exp_q.push_back(IRL | b2(2));            // F2: IR <- mem
    exp_q.push_back(15'h0000);               // D3
    case (op)
      8'h86, 8'h88: begin
        reg_ld = (op == 8'h86) ? AL : BL;
        exp_q.push_back(MARL | b2(1));
        exp_q.push_back(PCI);
        exp_q.push_back(b2(2) | reg_ld);
      end
      8'h87, 8'h89: begin
        reg_ld = (op == 8'h87) ? AL : BL;
        exp_q.push_back(MARL | b2(1));
        exp_q.push_back(PCI);
        exp_q.push_back(b2(2) | MARL);
        exp_q.push_back(15'h0000);
        exp_q.push_back(b2(2) | reg_ld);
      end
      8'h96, 8'h97: begin
        exp_q.push_back(MARL | b2(1));
        exp_q.push_back(PCI);
        exp_q.push_back(b2(2) | MARL);
        exp_q.push_back(b1((op == 8'h96) ? 1 : 2) | WR);
      end
      8'h42: exp_q.push_back(alu(0) | b1(1) | AL | CCL);
      8'h43: exp_q.push_back(alu(1) | b1(1) | AL | CCL);
      8'h44: exp_q.push_back(alu(2) | b1(1) | AL | CCL);
      8'h45: exp_q.push_back(alu(3) | b1(1) | AL | CCL);
      8'h46: exp_q.push_back(alu(4) | b1(1) | AL | CCL);
      8'h48: exp_q.push_back(alu(5) | b1(1) | AL | CCL);
      8'h47: exp_q.push_back(alu(4) | b1(2) | BL | CCL);
      8'h49: exp_q.push_back(alu(5) | b1(2) | BL | CCL);
      default: begin
        if (op >= 8'h20 && op <= 8'h28) begin
          k = int'(op) - 32;
          // Odd k tests flag==1, even k (2..8) tests flag==0; flags N,Z,V,C.
          if (k == 0) taken = 1'b1;
          else        taken = (ccr[3 - (k - 1) / 2] == ((k % 2) == 1));
          if (taken) begin
            exp_q.push_back(MARL | b2(1));
            exp_q.push_back(15'h0000);
            exp_q.push_back(b2(2) | PCL);
          end else begin
            exp_q.push_back(PCI);
          end
        end
      end
    endcase
  endtask

  // Per-cycle comparison against the model sequence.
  always @(negedge clk) begin
    if (exp_q.size() > 0) chk("cycle", act, exp_q.pop_front());
  end

  // Called at posedge+1 with the DUT in F0; returns at posedge+1 in the next F0.
  task automatic run_instr(input logic [7:0] op, input logic [3:0] ccr, input int len);
    int n;
    IR = op;
    CCR_Result = ccr;
    model(op, ccr);
    n = exp_q.size();
    if (len >= 0) chk("length", 15'(n), 15'(len));
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    IR = 8'h97;
    CCR_Result = 4'b1111;
    // Reset held with arbitrary IR: all outputs zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      IR = 8'(i * 8'h35 + 8'h86);
      chk("reset_zero", act, 15'h0000);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("release_f0", act, 15'h2002);
    #1;

    // Hand-computed pins of the model itself.
    model(8'h49, 4'b0000);
    chk("pin_decb", exp_q[4], 15'b000001110110000);
    exp_q.delete();
    model(8'h97, 4'b0000);
    chk("pin_stb", exp_q[7], 15'h0011);
    exp_q.delete();
    model(8'h23, 4'b0100);
    chk("pin_beq", exp_q[6], 15'h1004);
    exp_q.delete();

    run_instr(8'h86, 4'b0000, 7);
    run_instr(8'h88, 4'b0000, 7);
    run_instr(8'h87, 4'b0000, 9);
    run_instr(8'h89, 4'b0000, 9);
    run_instr(8'h96, 4'b0000, 8);
    run_instr(8'h97, 4'b0000, 8);
    run_instr(8'h42, 4'b0000, 5);
    run_instr(8'h43, 4'b0000, 5);
    run_instr(8'h44, 4'b0000, 5);
    run_instr(8'h45, 4'b0000, 5);
    run_instr(8'h46, 4'b0000, 5);
    run_instr(8'h47, 4'b0000, 5);
    run_instr(8'h48, 4'b0000, 5);
    run_instr(8'h49, 4'b0000, 5);
    run_instr(8'h23, 4'b0100, 7);
    run_instr(8'h23, 4'b0000, 5);
    run_instr(8'hFF, 4'b1111, 4);
    run_instr(8'h00, 4'b0000, 4);

    // All branch opcodes against every flag combination.
    for (int op = 8'h20; op <= 8'h28; op++)
      for (int f = 0; f < 16; f++)
        run_instr(8'(op), 4'(f), -1);

    // Reset during the write cycle of a store.
    IR = 8'h96;
    CCR_Result = 4'b0000;
    repeat (7) @(posedge clk);
    #1;
    chk("sta_e7", act, 15'h0009);
    #2;
    reset = 1'b0;
    #1;
    chk("reset_async", act, 15'h0000);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("reset_hold", act, 15'h0000);
    end
    reset = 1'b1;
    #1;
    chk("rerelease_f0", act, 15'h2002);
    #1;
    run_instr(8'h42, 4'b0000, 5);
    run_instr(8'h21, 4'b1000, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
